// File: rtl/alu_operand_fetch.sv
// Decode and operand-fetch stage feeding the 64-bit ALU.
// Accepts RV64I OP / OP-IMM instructions, reads a 32x64 register file with a
// same-cycle write bypass, and presents decoded operands from a single-entry
// registered slot. Handshake contract on both sides: a transfer happens on a
// rising edge where valid and ready are both high; valid never depends on
// ready, and instr_ready = !op_valid || op_ready is the only combinational path.
module alu_operand_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [63:0] A,
    output logic [63:0] B,
    output logic [5:0]  shamt,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  rd,
    output logic        is_cmp,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // Register file; entry 0 is held at zero so x0 reads as 0.
    logic [63:0] rf_q [32];
    logic [63:0] rf_d [32];

    // Output slot plus the source indices needed to refresh a held slot.
    logic        op_valid_q, op_valid_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [5:0]  shamt_q, shamt_d;
    logic [2:0]  func3_q, func3_d;
    logic [6:0]  func7_q, func7_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_cmp_q, is_cmp_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  slot_rs1_q, slot_rs1_d;
    logic [4:0]  slot_rs2_q, slot_rs2_d;
    logic        slot_is_r_q, slot_is_r_d;

    // Decode signals
    logic [6:0]  opcode;
    logic [2:0]  dec_f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_r_op;
    logic        is_i_op;
    logic        legal;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] dec_b;
    logic [5:0]  dec_shamt;
    logic [6:0]  dec_f7;
    logic        accept;
    logic        load;
    logic        wb_hit_rs1;
    logic        wb_hit_rs2;

    assign instr_ready = !op_valid_q || op_ready;
    assign accept      = instr_valid && instr_ready;
    assign load        = accept && legal;

    assign op_valid = op_valid_q;
    assign A        = a_q;
    assign B        = b_q;
    assign shamt    = shamt_q;
    assign func3    = func3_q;
    assign func7    = func7_q;
    assign rd       = rd_q;
    assign is_cmp   = is_cmp_q;
    assign illegal  = illegal_q;

    // Register-file next state: writes to x0 are dropped.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (wb_en && (wb_rd != 5'd0)) begin
            rf_d[wb_rd] = wb_data;
        end
        rf_d[0] = '0;
    end

    // Instruction decode, legality check and bypassed operand read.
    always_comb begin
        opcode  = instr[6:0];
        dec_f3  = instr[14:12];
        rs1     = instr[19:15];
        rs2     = instr[24:20];
        is_r_op = (opcode == OPC_OP);
        is_i_op = (opcode == OPC_OP_IMM);

        legal = 1'b0;
        if (is_r_op) begin
            legal = (instr[31:25] == 7'b0000000) ||
                    ((instr[31:25] == 7'b0100000) &&
                     ((dec_f3 == 3'b000) || (dec_f3 == 3'b101)));
        end else if (is_i_op) begin
            case (dec_f3)
                3'b001:  legal = (instr[31:26] == 6'b000000);
                3'b101:  legal = (instr[31:26] == 6'b000000) ||
                                 (instr[31:26] == 6'b010000);
                default: legal = 1'b1;
            endcase
        end

        // A write landing this cycle wins over the stored value.
        rs1_val = '0;
        if (rs1 != 5'd0) begin
            rs1_val = (wb_en && (wb_rd == rs1)) ? wb_data : rf_q[rs1];
        end
        rs2_val = '0;
        if (rs2 != 5'd0) begin
            rs2_val = (wb_en && (wb_rd == rs2)) ? wb_data : rf_q[rs2];
        end

        if (is_r_op) begin
            dec_b     = rs2_val;
            dec_shamt = rs2_val[5:0];
            dec_f7    = instr[31:25];
        end else begin
            dec_b     = {{52{instr[31]}}, instr[31:20]};
            dec_shamt = instr[25:20];
            if ((dec_f3 == 3'b001) || (dec_f3 == 3'b101)) begin
                dec_f7 = {instr[31:26], 1'b0};
            end else begin
                dec_f7 = 7'b0000000;
            end
        end
    end

    // Slot next state: load on legal accept, drain on op_ready, else hold and refresh.
    always_comb begin
        op_valid_d  = op_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        shamt_d     = shamt_q;
        func3_d     = func3_q;
        func7_d     = func7_q;
        rd_d        = rd_q;
        is_cmp_d    = is_cmp_q;
        slot_rs1_d  = slot_rs1_q;
        slot_rs2_d  = slot_rs2_q;
        slot_is_r_d = slot_is_r_q;
        illegal_d   = accept && !legal;

        wb_hit_rs1 = wb_en && (wb_rd != 5'd0) && (wb_rd == slot_rs1_q);
        wb_hit_rs2 = wb_en && (wb_rd != 5'd0) && (wb_rd == slot_rs2_q) && slot_is_r_q;

        if (load) begin
            op_valid_d  = 1'b1;
            a_d         = rs1_val;
            b_d         = dec_b;
            shamt_d     = dec_shamt;
            func3_d     = dec_f3;
            func7_d     = dec_f7;
            rd_d        = instr[11:7];
            is_cmp_d    = (dec_f3 == 3'b010) || (dec_f3 == 3'b011);
            slot_rs1_d  = rs1;
            slot_rs2_d  = rs2;
            slot_is_r_d = is_r_op;
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end else if (op_valid_q) begin
            // Held slot: track writeback so the ALU never sees stale operands.
            if (wb_hit_rs1) begin
                a_d = wb_data;
            end
            if (wb_hit_rs2) begin
                b_d     = wb_data;
                shamt_d = wb_data[5:0];
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
            op_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            shamt_q     <= '0;
            func3_q     <= '0;
            func7_q     <= '0;
            rd_q        <= '0;
            is_cmp_q    <= 1'b0;
            illegal_q   <= 1'b0;
            slot_rs1_q  <= '0;
            slot_rs2_q  <= '0;
            slot_is_r_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
            op_valid_q  <= op_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            shamt_q     <= shamt_d;
            func3_q     <= func3_d;
            func7_q     <= func7_d;
            rd_q        <= rd_d;
            is_cmp_q    <= is_cmp_d;
            illegal_q   <= illegal_d;
            slot_rs1_q  <= slot_rs1_d;
            slot_rs2_q  <= slot_rs2_d;
            slot_is_r_q <= slot_is_r_d;
        end
    end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Testbench for alu_operand_fetch: directed vector table, hand-written reset
// sequences, and randomized traffic checked against a behavioural model.
module tb_alu_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        op_valid;
    logic        op_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic [5:0]  shamt;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic        is_cmp;
    logic        illegal;

    int checks_total  = 0;
    int checks_passed = 0;

    alu_operand_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .A           (A),
        .B           (B),
        .shamt       (shamt),
        .func3       (func3),
        .func7       (func7),
        .rd          (rd),
        .is_cmp      (is_cmp),
        .illegal     (illegal)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural model: architectural registers plus what the ALU should see.
    logic [63:0] mrf [32];
    logic        m_valid;
    logic [63:0] m_a;
    logic [63:0] m_b;
    logic [5:0]  m_sh;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [4:0]  m_rd;
    logic        m_cmp;
    logic        m_ill;
    logic [4:0]  m_rs1;
    logic [4:0]  m_rs2;
    logic        m_isr;

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic        we;
        logic [4:0]  wrd;
        logic [63:0] wd;
        logic        ordy;
        logic        e_rdy;
        logic        e_valid;
        logic        e_ill;
        logic [63:0] e_a;
        logic [63:0] e_b;
        logic [5:0]  e_sh;
        logic [2:0]  e_f3;
        logic [6:0]  e_f7;
        logic [4:0]  e_rd;
        logic        e_cmp;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {imm, s1, f3, d, 7'b0010011};
    endfunction

    function automatic bit m_legal(input logic [31:0] w);
        logic [2:0] f3;
        f3 = w[14:12];
        if (w[6:0] == 7'b0110011) begin
            return (w[31:25] == 7'h00) || (w[31:25] == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end
        if (w[6:0] == 7'b0010011) begin
            if (f3 == 3'd1) return w[31:26] == 6'h00;
            if (f3 == 3'd5) return (w[31:26] == 6'h00) || (w[31:26] == 6'h10);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        m_valid = 1'b0; m_a = '0; m_b = '0; m_sh = '0; m_f3 = '0; m_f7 = '0;
        m_rd = '0; m_cmp = 1'b0; m_ill = 1'b0; m_rs1 = '0; m_rs2 = '0; m_isr = 1'b0;
    endtask

    // Register value a reader sees this cycle, including a same-cycle write.
    function automatic logic [63:0] m_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wrd, input logic [63:0] wd);
        if (r == 5'd0) return '0;
        if (we && wrd == r) return wd;
        return mrf[r];
    endfunction

    task automatic compare_outputs();
        chk("op_valid", {63'b0, op_valid}, {63'b0, m_valid});
        chk("illegal", {63'b0, illegal}, {63'b0, m_ill});
        if (m_valid) begin
            chk("A", A, m_a);
            chk("B", B, m_b);
            chk("shamt", {58'b0, shamt}, {58'b0, m_sh});
            chk("func3", {61'b0, func3}, {61'b0, m_f3});
            chk("func7", {57'b0, func7}, {57'b0, m_f7});
            chk("rd", {59'b0, rd}, {59'b0, m_rd});
            chk("is_cmp", {63'b0, is_cmp}, {63'b0, m_cmp});
        end
    endtask

    // One clock cycle: drive at negedge, check ready, advance model, check after edge.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic we,
                         input logic [4:0] wrd, input logic [63:0] wd, input logic ordy);
        logic        acc;
        logic [2:0]  f3;
        logic [63:0] v2;
        @(negedge clk);
        instr_valid = iv; instr = ins; wb_en = we; wb_rd = wrd; wb_data = wd; op_ready = ordy;
        #1;
        chk("instr_ready", {63'b0, instr_ready}, {63'b0, (!m_valid || ordy)});
        acc = iv && (!m_valid || ordy);
        m_ill = acc && !m_legal(ins);
        if (acc && m_legal(ins)) begin
            f3      = ins[14:12];
            m_valid = 1'b1;
            m_isr   = (ins[6:0] == 7'b0110011);
            m_rs1   = ins[19:15];
            m_rs2   = ins[24:20];
            m_a     = m_read(m_rs1, we, wrd, wd);
            m_f3    = f3;
            m_rd    = ins[11:7];
            m_cmp   = (f3 == 3'd2) || (f3 == 3'd3);
            if (m_isr) begin
                v2   = m_read(m_rs2, we, wrd, wd);
                m_b  = v2;
                m_sh = v2[5:0];
                m_f7 = ins[31:25];
            end else begin
                m_b  = {{52{ins[31]}}, ins[31:20]};
                m_sh = ins[25:20];
                m_f7 = (f3 == 3'd1 || f3 == 3'd5) ? {ins[31:26], 1'b0} : 7'd0;
            end
        end else if (ordy) begin
            m_valid = 1'b0;
        end else if (m_valid && we && wrd != 5'd0) begin
            if (wrd == m_rs1) m_a = wd;
            if (m_isr && wrd == m_rs2) begin
                m_b  = wd;
                m_sh = wd[5:0];
            end
        end
        if (we && wrd != 5'd0) mrf[wrd] = wd;
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst op_valid", {63'b0, op_valid}, 64'd0);
        chk("rst illegal", {63'b0, illegal}, 64'd0);
        chk("rst instr_ready", {63'b0, instr_ready}, 64'd1);
        chk("rst A", A, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] rnd_ins;
    logic [63:0] rnd_wd;

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; wb_en = 1'b0;
        wb_rd = '0; wb_data = '0; op_ready = 1'b0;
        model_reset();

        // Directed vectors: inputs for one cycle, then the expected slot after the edge.
        vecs[0]  = '{1'b0, 32'h0, 1'b1, 5'd5, 64'h10, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0, 3'd0, 7'd0, 5'd0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0, 1'b1, 5'd6, 64'h3, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0, 3'd0, 7'd0, 5'd0, 1'b0};
        vecs[2]  = '{1'b1, enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd7), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b1, 1'b0, 64'h10, 64'h3, 6'd3, 3'd0, 7'h00, 5'd7, 1'b0};
        vecs[3]  = '{1'b0, 32'h0, 1'b1, 5'd2, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0, 3'd0, 7'd0, 5'd0, 1'b0};
        // srai x1,x2,63: imm field 0x43F has bit 11 clear, so its sign extension is positive.
        vecs[4]  = '{1'b1, enc_i(12'h43F, 5'd2, 3'd5, 5'd1), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h43F, 6'd63, 3'd5, 7'h20, 5'd1, 1'b0};
        vecs[5]  = '{1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b1, 1'b0, 64'h0, 64'h8000_0000_0000_0000, 6'd0, 3'd2, 7'h00, 5'd3, 1'b1};
        vecs[6]  = '{1'b1, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 6'h3F, 3'd0, 7'h00, 5'd1, 1'b0};
        vecs[7]  = '{1'b1, enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd8), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b1, 1'b0, 64'h10, 64'h0, 6'd0, 3'd0, 7'h00, 5'd8, 1'b0};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 5'd5, 64'hAA, 1'b0,
                     1'b0, 1'b1, 1'b0, 64'hAA, 64'h0, 6'd0, 3'd0, 7'h00, 5'd8, 1'b0};
        vecs[9]  = '{1'b1, enc_r(7'h20, 5'd5, 5'd6, 3'd0, 5'd9), 1'b0, 5'd0, 64'h0, 1'b0,
                     1'b0, 1'b1, 1'b0, 64'hAA, 64'h0, 6'd0, 3'd0, 7'h00, 5'd8, 1'b0};
        vecs[10] = '{1'b1, enc_r(7'h20, 5'd5, 5'd6, 3'd0, 5'd9), 1'b0, 5'd0, 64'h0, 1'b0,
                     1'b0, 1'b1, 1'b0, 64'hAA, 64'h0, 6'd0, 3'd0, 7'h00, 5'd8, 1'b0};
        vecs[11] = '{1'b1, enc_r(7'h20, 5'd5, 5'd6, 3'd0, 5'd9), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b1, 1'b0, 64'h3, 64'hAA, 6'h2A, 3'd0, 7'h20, 5'd9, 1'b0};
        vecs[12] = '{1'b1, enc_r(7'h00, 5'd6, 5'd5, 3'd6, 5'd10), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b1, 1'b0, 64'hAA, 64'h3, 6'd3, 3'd6, 7'h00, 5'd10, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0003, 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b0, 1'b1, 64'h0, 64'h0, 6'd0, 3'd0, 7'd0, 5'd0, 1'b0};
        vecs[14] = '{1'b0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0, 3'd0, 7'd0, 5'd0, 1'b0};
        vecs[15] = '{1'b1, enc_r(7'h20, 5'd6, 5'd5, 3'd4, 5'd11), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b0, 1'b1, 64'h0, 64'h0, 6'd0, 3'd0, 7'd0, 5'd0, 1'b0};
        vecs[16] = '{1'b0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0, 3'd0, 7'd0, 5'd0, 1'b0};
        vecs[17] = '{1'b1, enc_r(7'h00, 5'd0, 5'd3, 3'd6, 5'd4), 1'b1, 5'd3, 64'h55, 1'b1,
                     1'b1, 1'b1, 1'b0, 64'h55, 64'h0, 6'd0, 3'd6, 7'h00, 5'd4, 1'b0};
        vecs[18] = '{1'b0, 32'h0, 1'b1, 5'd0, 64'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0, 3'd0, 7'd0, 5'd0, 1'b0};
        vecs[19] = '{1'b1, enc_i(12'h005, 5'd0, 3'd0, 5'd12), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b1, 1'b0, 64'h0, 64'h5, 6'd5, 3'd0, 7'h00, 5'd12, 1'b0};
        vecs[20] = '{1'b1, enc_i(12'h040, 5'd1, 3'd1, 5'd2), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b0, 1'b1, 64'h0, 64'h0, 6'd0, 3'd0, 7'd0, 5'd0, 1'b0};
        vecs[21] = '{1'b1, enc_i(12'h003, 5'd5, 3'd1, 5'd13), 1'b0, 5'd0, 64'h0, 1'b1,
                     1'b1, 1'b1, 1'b0, 64'hAA, 64'h3, 6'd3, 3'd1, 7'h00, 5'd13, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        apply_reset();

        for (int i = 0; i < NVEC; i++) begin
            cycle(vecs[i].iv, vecs[i].ins, vecs[i].we, vecs[i].wrd, vecs[i].wd, vecs[i].ordy);
            // instr_ready was checked against the model inside cycle(); also pin it to the table.
            if (vecs[i].iv && !vecs[i].e_rdy) chk($sformatf("v%0d stalled", i), {63'b0, op_valid}, 64'd1);
            chk($sformatf("v%0d op_valid", i), {63'b0, op_valid}, {63'b0, vecs[i].e_valid});
            chk($sformatf("v%0d illegal", i), {63'b0, illegal}, {63'b0, vecs[i].e_ill});
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d A", i), A, vecs[i].e_a);
                chk($sformatf("v%0d B", i), B, vecs[i].e_b);
                chk($sformatf("v%0d shamt", i), {58'b0, shamt}, {58'b0, vecs[i].e_sh});
                chk($sformatf("v%0d func3", i), {61'b0, func3}, {61'b0, vecs[i].e_f3});
                chk($sformatf("v%0d func7", i), {57'b0, func7}, {57'b0, vecs[i].e_f7});
                chk($sformatf("v%0d rd", i), {59'b0, rd}, {59'b0, vecs[i].e_rd});
                chk($sformatf("v%0d is_cmp", i), {63'b0, is_cmp}, {63'b0, vecs[i].e_cmp});
            end
        end

        // Reset while a stalled slot is held drops it immediately.
        cycle(1'b0, 32'h0, 1'b0, 5'd0, 64'h0, 1'b1);
        cycle(1'b1, enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd7), 1'b0, 5'd0, 64'h0, 1'b0);
        chk("pre-reset op_valid", {63'b0, op_valid}, 64'd1);
        apply_reset();

        // Illegal pulse does not survive reset; registers come back cleared.
        cycle(1'b1, 32'h0000_0003, 1'b0, 5'd0, 64'h0, 1'b1);
        chk("pre-reset illegal", {63'b0, illegal}, 64'd1);
        apply_reset();
        cycle(1'b1, enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd7), 1'b0, 5'd0, 64'h0, 1'b1);
        chk("post-reset x5", A, 64'd0);
        chk("post-reset x6", B, 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0: rnd_ins = enc_r(7'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                   3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                1: rnd_ins = enc_r(7'h20, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                   3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                2: rnd_ins = enc_i(12'($urandom), 5'($urandom_range(0, 7)),
                                   3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                3: rnd_ins = enc_i({($urandom_range(0, 2) == 0) ? 6'($urandom) :
                                    (($urandom_range(0, 1) == 0) ? 6'h10 : 6'h00), 6'($urandom)},
                                   5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5,
                                   5'($urandom_range(0, 7)));
                4: rnd_ins = $urandom;
                default: rnd_ins = enc_r(7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                         3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            endcase
            rnd_wd = {$urandom, $urandom};
            cycle(1'($urandom_range(0, 3) != 0), rnd_ins, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), rnd_wd, 1'($urandom_range(0, 4) < 3));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
